regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clear_ctrl.sv | 60 ++++++
 rtl/regfile_param.sv | 77 +++++++
 tb/tb_regfile_param.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults
// for the parameterised register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// regfile_clear_ctrl: post-reset sweep that
// zeroes every register before normal use.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;

  // state and sweep index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // sweep one register per cycle, then run
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    clr_we      = 1'b0;
    unique case (r_state)
      CLEAR: begin
        clr_we    = 1'b1;
        w_idx_nxt = r_idx + ADDR_W'(1);
        if (r_idx == LAST) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_idx_nxt = '0;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  assign busy    = (r_state == CLEAR);
  assign clr_idx = r_idx;

endmodule

// File: rtl/regfile_param.sv
// regfile_param: 1W2R register file with
// write-first bypass and optional zero reg.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] replaceSel,
  input  logic [DATA_W-1:0] replaceData,
  input  logic [ADDR_W-1:0] A_sel,
  input  logic [ADDR_W-1:0] B_sel,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              busy
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_wr_ok;

  regfile_clear_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (w_busy),
    .clr_we  (w_clr_we),
    .clr_idx (w_clr_idx)
  );

  assign busy = w_busy;

  assign w_wr_ok = we && !w_busy &&
    !(ZR && (replaceSel == '0));

  // storage: clear sweep has priority,
  // contents deliberately not reset
  always_ff @(posedge clk) begin
    if (w_busy && w_clr_we) begin
      r_regs[w_clr_idx] <= '0;
    end else if (w_wr_ok) begin
      r_regs[replaceSel] <= replaceData;
    end
  end

  function automatic logic [DATA_W-1:0]
    rd(input logic [ADDR_W-1:0] sel);
    logic [DATA_W-1:0] v;
    v = r_regs[sel];
    if (w_busy) begin
      v = '0;
    end else if (ZR && (sel == '0)) begin
      v = '0;
    end else if (we && (sel == replaceSel)) begin
      v = replaceData;
    end
    return v;
  endfunction

  // read ports with bypass and masking
  always_comb begin
    A = rd(A_sel);
    B = rd(B_sel);
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: vector table, directed
// corner sequences and random checking.
module tb_regfile_param;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] replaceSel = '0;
  logic [DW-1:0] replaceData = '0;
  logic [AW-1:0] A_sel = '0;
  logic [AW-1:0] B_sel = '0;
  logic [DW-1:0] A, B, Az, Bz;
  logic          busy, busyz;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mdl  [DP];
  logic [DW-1:0] mdlz [DP];
  int            clr_left = 0;

  always #5 clk = ~clk;

  regfile_param #(
    .DATA_W(DW), .DEPTH(DP), .ZERO_REG(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .we(we),
    .replaceSel(replaceSel),
    .replaceData(replaceData),
    .A_sel(A_sel), .B_sel(B_sel),
    .A(A), .B(B), .busy(busy)
  );

  regfile_param #(
    .DATA_W(DW), .DEPTH(DP), .ZERO_REG(1)
  ) u_dz (
    .clk(clk), .rst_n(rst_n), .we(we),
    .replaceSel(replaceSel),
    .replaceData(replaceData),
    .A_sel(A_sel), .B_sel(B_sel),
    .A(Az), .B(Bz), .busy(busyz)
  );

  task automatic chk(input string nm,
    input logic [DW-1:0] act,
    input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h t=%0t",
        nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(
    input bit zr, input logic [AW-1:0] s);
    if (clr_left > 0) return '0;
    if (zr && s == 0) return '0;
    if (we && s == replaceSel) return replaceData;
    return zr ? mdlz[s] : mdl[s];
  endfunction

  // one cycle: called at posedge+1
  task automatic step(input bit w,
    input logic [AW-1:0] s,
    input logic [DW-1:0] d,
    input logic [AW-1:0] a,
    input logic [AW-1:0] b,
    output logic [DW-1:0] oa,
    output logic [DW-1:0] ob,
    output logic [DW-1:0] oaz);
    we = w; replaceSel = s; replaceData = d;
    A_sel = a; B_sel = b;
    #2;
    chk("busy", 8'(busy), 8'(clr_left > 0));
    chk("busyz", 8'(busyz), 8'(clr_left > 0));
    chk("A", A, ref_rd(1'b0, a));
    chk("B", B, ref_rd(1'b0, b));
    chk("Az", Az, ref_rd(1'b1, a));
    chk("Bz", Bz, ref_rd(1'b1, b));
    oa = A; ob = B; oaz = Az;
    @(posedge clk);
    #1;
    if (clr_left > 0) begin
      clr_left--;
    end else if (w) begin
      mdl[s] = d;
      if (s != 0) mdlz[s] = d;
    end
  endtask

  // reset pulse; called at posedge+1
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 8'(busy), 8'd1);
    chk("rst_A", A, 8'h00);
    chk("rst_Bz", Bz, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_left = DP;
    foreach (mdl[i]) begin
      mdl[i] = '0;
      mdlz[i] = '0;
    end
  endtask

  typedef struct {
    bit            w;
    logic [AW-1:0] s;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic [DW-1:0] eaz;
  } vec_t;

  vec_t tbl [9];
  logic [DW-1:0] ra, rb, raz;
  int cyc;

  initial begin
    tbl[0] = '{1, 3, 8'hA5, 0, 0, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{1, 7, 8'h3C, 3, 3, 8'hA5, 8'hA5, 8'hA5};
    tbl[2] = '{0, 0, 8'h00, 3, 7, 8'hA5, 8'h3C, 8'hA5};
    tbl[3] = '{1, 5, 8'h77, 5, 5, 8'h77, 8'h77, 8'h77};
    tbl[4] = '{0, 0, 8'h00, 5, 3, 8'h77, 8'hA5, 8'h77};
    tbl[5] = '{1, 0, 8'h55, 0, 7, 8'h55, 8'h3C, 8'h00};
    tbl[6] = '{0, 0, 8'h00, 0, 5, 8'h55, 8'h77, 8'h00};
    tbl[7] = '{1, 3, 8'hFF, 3, 7, 8'hFF, 8'h3C, 8'hFF};
    tbl[8] = '{0, 0, 8'h00, 3, 3, 8'hFF, 8'hFF, 8'hFF};

    #2;
    @(posedge clk);
    #1;
    do_reset();

    // write to reg 2 throughout the clear
    for (int i = 0; i < DP; i++) begin
      step(1, 2, 8'hFF, 2, 2, ra, rb, raz);
    end
    step(0, 0, 0, 2, 0, ra, rb, raz);
    chk("busywr_r2", ra, 8'h00);

    // every register reads zero
    for (int i = 0; i < DP; i++) begin
      step(0, 0, 0, AW'(i), AW'(DP-1-i),
        ra, rb, raz);
      chk("clr_rd", ra, 8'h00);
    end

    // vector table
    foreach (tbl[i]) begin
      step(tbl[i].w, tbl[i].s, tbl[i].d,
        tbl[i].a, tbl[i].b, ra, rb, raz);
      chk($sformatf("tbl%0d_A", i), ra, tbl[i].ea);
      chk($sformatf("tbl%0d_B", i), rb, tbl[i].eb);
      chk($sformatf("tbl%0d_Az", i), raz,
        tbl[i].eaz);
    end

    // random traffic vs model
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 1) == 1,
        AW'($urandom), DW'($urandom),
        AW'($urandom), AW'($urandom),
        ra, rb, raz);
    end

    // fill everything, then reset mid-run
    do_reset();
    cyc = 0;
    for (int i = 0; i < DP; i++) begin
      step(0, 0, 0, 0, 0, ra, rb, raz);
      cyc++;
    end
    for (int i = 0; i < DP; i++) begin
      step(1, AW'(i), DW'(8'h80 + i),
        0, 0, ra, rb, raz);
      cyc++;
    end
    while (cyc < 40) begin
      step(0, 0, 0, AW'(cyc), AW'(cyc + 1),
        ra, rb, raz);
      cyc++;
    end
    step(0, 0, 0, 9, 9, ra, rb, raz);
    chk("pre_rst_r9", ra, 8'h89);
    do_reset();
    for (int i = 0; i < DP + 1; i++) begin
      step(1, 4, 8'h11, 4, 9, ra, rb, raz);
    end
    for (int i = 0; i < DP; i++) begin
      step(0, 0, 0, AW'(i), AW'(i),
        ra, rb, raz);
      if (i != 4) chk("post_rst_rd", ra, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
